// File: rtl/program_loader.sv
// Instruction-memory loader: streams a program into local memory, then serves
// zero-latency instruction fetches to the CPU until the next load request.
module program_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          cpu_run,
  output logic [AW:0]   word_count,
  output logic          load_error,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t         r_state;
  logic [AW:0]    r_word_count;
  logic [31:0]    r_mem [DEPTH];

  logic           w_accept;
  logic [AW-1:0]  w_idx;
  logic           w_hit;

  // Handshake: a beat transfers on a rising edge where load_valid && load_ready;
  // load_ready depends on state only, and load_last is meaningful only with load_valid.
  assign w_accept = (r_state == S_LOAD) && load_valid;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_word_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state      <= S_LOAD;
            r_word_count <= '0;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            r_word_count <= r_word_count + (AW+1)'(1);
            if (load_last)
              r_state <= S_RUN;
            else if (r_word_count == LAST_IDX)
              r_state <= S_ERR;
          end
        end
        S_RUN, S_ERR: begin
          if (load_start) begin
            r_state      <= S_LOAD;
            r_word_count <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory is never cleared; word_count gates every read instead.
  always_ff @(posedge CLK) begin
    if (w_accept)
      r_mem[r_word_count[AW-1:0]] <= load_data;
  end

  assign w_idx = pc[AW+1:2];
  assign w_hit = (r_state == S_RUN) && (pc[1:0] == 2'b00) &&
                 (pc[31:AW+2] == '0) && ({1'b0, w_idx} < r_word_count);

  assign instr      = w_hit ? r_mem[w_idx] : 32'h0000_0000;
  assign load_ready = (r_state == S_LOAD);
  assign cpu_run    = (r_state == S_RUN);
  assign load_error = (r_state == S_ERR);
  assign word_count = r_word_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, fetch, overflow, valid gaps,
// asynchronous reset mid-load and reload from RUN.
module tb_program_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_LOAD = 32'd1;
  localparam logic [31:0] ST_RUN  = 32'd2;
  localparam logic [31:0] ST_ERR  = 32'd3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          load_start;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          cpu_run;
  logic [AW:0]   word_count;
  logic          load_error;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .pc         (pc),
    .instr      (instr),
    .cpu_run    (cpu_run),
    .word_count (word_count),
    .load_error (load_error),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge, outputs sampled there too
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    check(tag, instr, exp);
  endtask

  task automatic check_status(input string tag, input logic [31:0] st, input logic [31:0] wc,
                              input logic rdy, input logic run, input logic err);
    check({tag, "_state"}, {30'd0, dbg_state}, st);
    check({tag, "_wc"},    {26'd0, word_count}, wc);
    check({tag, "_ready"}, {31'd0, load_ready}, {31'd0, rdy});
    check({tag, "_run"},   {31'd0, cpu_run},    {31'd0, run});
    check({tag, "_err"},   {31'd0, load_error}, {31'd0, err});
  endtask

  // scoreboard: words of the current program, fetched back by index
  task automatic check_program(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      fetch($sformatf("%s_w%0d", tag, i), 32'(i * 4), exp_q[i]);
    fetch({tag, "_past_end"}, 32'(exp_q.size() * 4), 32'h0);
  endtask

  initial begin
    RESET      = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    load_last  = 1'b0;
    pc         = 32'h0;
    #3;
    check_status("reset", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    check("reset_instr", instr, 32'h0);
    step();
    step();
    RESET = 1'b0;
    step();

    // idle ignores stray beats
    beat(32'hdead_beef, 1'b1);
    check_status("idle_hold", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);

    // basic 3-word load
    start_load();
    check_status("load_enter", ST_LOAD, 0, 1'b1, 1'b0, 1'b0);
    beat(32'h0000_4820, 1'b0);
    beat(32'h2009_0002, 1'b0);
    check_status("load_mid", ST_LOAD, 2, 1'b1, 1'b0, 1'b0);
    beat(32'hac09_0000, 1'b1);
    check_status("basic_run", ST_RUN, 3, 1'b0, 1'b1, 1'b0);
    fetch("basic_pc4", 32'h4, 32'h2009_0002);
    exp_q = '{32'h0000_4820, 32'h2009_0002, 32'hac09_0000};
    check_program("basic");
    fetch("oor_pc12", 32'd12, 32'h0);
    fetch("oor_pc6", 32'd6, 32'h0);
    fetch("oor_pc100", 32'h100, 32'h0);
    fetch("oor_pc_hi", 32'h8000_0004, 32'h0);

    // RUN ignores beats and freezes word_count
    beat(32'h1111_1111, 1'b1);
    step();
    check_status("run_frozen", ST_RUN, 3, 1'b0, 1'b1, 1'b0);

    // overflow: 32 beats without last
    start_load();
    check_status("ovf_enter", ST_LOAD, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++)
      beat(32'h1000_0000 + 32'(i), 1'b0);
    check_status("ovf_31", ST_LOAD, 31, 1'b1, 1'b0, 1'b0);
    beat(32'h1000_001f, 1'b0);
    check_status("ovf_err", ST_ERR, 32, 1'b0, 1'b0, 1'b1);
    fetch("ovf_instr", 32'h0, 32'h0);
    step();
    check_status("ovf_sticky", ST_ERR, 32, 1'b0, 1'b0, 1'b1);
    start_load();
    check_status("ovf_clear", ST_LOAD, 0, 1'b1, 1'b0, 1'b0);

    // valid gaps: last while valid=0 is ignored, as is load_start in LOAD
    beat(32'haaaa_0001, 1'b0);
    check("gap_wc1", {26'd0, word_count}, 32'd1);
    load_last = 1'b1;
    step();
    load_last = 1'b0;
    check_status("gap_last_ignored", ST_LOAD, 1, 1'b1, 1'b0, 1'b0);
    start_load();
    check_status("gap_start_ignored", ST_LOAD, 1, 1'b1, 1'b0, 1'b0);
    beat(32'haaaa_0002, 1'b0);
    check_status("gap_wc2", ST_LOAD, 2, 1'b1, 1'b0, 1'b0);
    beat(32'haaaa_0003, 1'b1);
    check_status("gap_run", ST_RUN, 3, 1'b0, 1'b1, 1'b0);
    exp_q = '{32'haaaa_0001, 32'haaaa_0002, 32'haaaa_0003};
    check_program("gap");

    // reset in the middle of a 4-beat load
    start_load();
    beat(32'hbbbb_0001, 1'b0);
    beat(32'hbbbb_0002, 1'b0);
    check("rst_pre_wc", {26'd0, word_count}, 32'd2);
    RESET = 1'b1;
    #2;
    check_status("rst_async", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      fetch($sformatf("rst_instr%0d", i), 32'(i * 4), 32'h0);
    step();
    RESET = 1'b0;
    beat(32'hbbbb_0003, 1'b0);
    beat(32'hbbbb_0004, 1'b1);
    check_status("rst_idle", ST_IDLE, 0, 1'b0, 1'b0, 1'b0);
    fetch("rst_idle_instr", 32'h0, 32'h0);

    // reload from RUN
    start_load();
    beat(32'hcccc_0001, 1'b0);
    beat(32'hcccc_0002, 1'b1);
    check_status("reload_run", ST_RUN, 2, 1'b0, 1'b1, 1'b0);
    fetch("reload_pre_pc4", 32'h4, 32'hcccc_0002);
    start_load();
    check_status("reload_drop", ST_LOAD, 0, 1'b1, 1'b0, 1'b0);
    fetch("reload_load_instr", 32'h0, 32'h0);
    beat(32'hdddd_0001, 1'b1);
    check_status("reload_done", ST_RUN, 1, 1'b0, 1'b1, 1'b0);
    exp_q = '{32'hdddd_0001};
    check_program("reload");
    fetch("reload_pc4", 32'h4, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the instruction memory size in 32-bit words.
REQ-002 SHALL have parameter AW, default 5, meaning the word-index width (DEPTH = 2^AW).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port load_start  input  1  request to begin a new program load.
REQ-006 SHALL have port load_valid  input  1  load_data holds a valid program word.
REQ-007 SHALL have port load_data  input  32  program word, in ascending address order.
REQ-008 SHALL have port load_last  input  1  the current beat is the final word.
REQ-009 SHALL have port load_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port pc  input  32  byte address from the CPU program counter.
REQ-011 SHALL have port instr  output  32  instruction word delivered to the CPU.
REQ-012 SHALL have port cpu_run  output  1  CPU may execute; low holds the CPU stalled.
REQ-013 SHALL have port word_count  output  AW+1  number of words loaded so far, 0..DEPTH.
REQ-014 SHALL have port load_error  output  1  overflow error, sticky until the next load_start.

Function
REQ-015 SHALL implement a registered FSM with states IDLE, LOAD, RUN and ERR.
REQ-016 SHALL, in IDLE, keep load_ready=0 and cpu_run=0, and on load_start go to LOAD with word_count cleared to 0.
REQ-017 SHALL, in LOAD, drive load_ready=1 combinationally from state only; no dependency on load_valid.
REQ-018 SHALL accept a beat when load_valid and load_ready are high at a rising edge: mem[word_count] <= load_data, word_count <= word_count+1.
REQ-019 SHALL, on an accepted beat with load_last=1, move to RUN on that same edge, so cpu_run=1 in the following cycle.
REQ-020 SHALL, on an accepted beat with word_count==DEPTH-1 and load_last=0, write the word, set word_count=DEPTH and move to ERR.
REQ-021 SHALL ignore load_last when load_valid=0, and ignore load_start while in LOAD.
REQ-022 SHALL, in RUN, hold cpu_run=1, load_ready=0, and word_count frozen.
REQ-023 SHALL, in RUN, drive instr combinationally (zero-cycle read) as mem[pc[AW+1:2]] when pc[1:0]==0, pc[31:AW+2]==0 and pc[AW+1:2] < word_count; otherwise instr = 32'h00000000 (NOP).
REQ-024 SHALL drive instr = 32'h00000000 in every state other than RUN.
REQ-025 SHALL, on load_start in RUN, go to LOAD with word_count=0; cpu_run is low from the next cycle onward.
REQ-026 SHALL, in ERR, drive load_error=1, cpu_run=0 and load_ready=0, and on load_start go to LOAD, clearing load_error and word_count.
REQ-027 SHALL NOT clear memory on reload or reset; stale words are unreachable because word_count gates reads.

Reset
REQ-028 SHALL, while RESET=1, force state=IDLE, word_count=0, load_error=0, cpu_run=0, load_ready=0 and instr=0, independent of CLK.
REQ-029 SHALL, on RESET during LOAD or RUN, abort the operation immediately; after release the block idles until load_start.

Verification
REQ-030 SHALL cover basic load: load_start, then 3 beats 32'h00004820, 32'h20090002, 32'hac090000 (last on beat 3) -> word_count=3, cpu_run=1 on the next cycle; pc=4 gives instr=32'h20090002.
REQ-031 SHALL cover out-of-range reads: after the 3-word load, pc=12 gives instr=0; pc=6 (misaligned) gives instr=0; pc=32'h100 gives instr=0.
REQ-032 SHALL cover overflow: 32 beats with load_last=0 -> word_count=32, load_error=1, cpu_run=0; a following load_start clears load_error.
REQ-033 SHALL cover valid gaps: load_valid toggled 1,0,1 with load_last asserted only while valid=0 -> no transition; word_count advances only on valid beats.
REQ-034 SHALL cover reset mid-load: RESET pulsed after 2 of 4 beats -> outputs reset asynchronously, word_count=0, state IDLE, and instr=0 for every pc.
REQ-035 SHALL cover reload from RUN: load_start in RUN -> cpu_run drops next cycle and a 1-word reload gives word_count=1, with pc=4 returning 0.
